// File: rtl/fpdiv_pkg.sv
// fpdiv_pkg: shared types and constants for the divider special-case controller
package fpdiv_pkg;

    typedef enum logic [1:0] {IDLE, CORE_WAIT, OUT_HOLD} state_e;

    typedef enum logic [2:0] {ZERO, SUB, NORM, INF, QNAN, SNAN} fpClass_e;

    function automatic logic [63:0] qnan(int expW, int manW);
        logic [63:0] q = '0;
        for (int i = 0; i < expW; i++) q[manW+i] = 1'b1;
        q[manW-1] = 1'b1;
        return q;
    endfunction

endpackage

// File: rtl/fp_classify.sv
// fp_classify: combinational operand class decode (sign excluded)
module fp_classify
    import fpdiv_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter bit DAZ   = 1'b1
) (
    input  logic [EXP_W+MAN_W-1:0] op,
    output fpClass_e               cls
);
    logic expOnes, expZero, manZero;
    assign expOnes = &op[MAN_W+:EXP_W];
    assign expZero = ~|op[MAN_W+:EXP_W];
    assign manZero = ~|op[MAN_W-1:0];
    assign cls = expOnes ? (manZero ? INF : (op[MAN_W-1] ? QNAN : SNAN)) :
                 expZero ? ((manZero || DAZ) ? ZERO : SUB) : NORM;
endmodule

// File: rtl/fpdiv_special_ctrl.sv
// fpdiv_special_ctrl: resolves special operands in one cycle, dispatches finite/finite
// divides to the iterative core and returns quotient plus flags over valid/ready.
module fpdiv_special_ctrl
    import fpdiv_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter bit DAZ   = 1'b1,
    localparam int W    = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         core_start,
    output logic [W-1:0] core_a,
    output logic [W-1:0] core_b,
    input  logic         core_done,
    input  logic [W-1:0] core_result,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_result,
    output logic         out_invalid,
    output logic         out_divzero
);
    localparam logic [W-1:0] qnanVal = W'(qnan(EXP_W, MAN_W));

    state_e   state;
    fpClass_e clsA, clsB;

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W), .DAZ(DAZ)) uClsA (.op(in_a[W-2:0]), .cls(clsA));
    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W), .DAZ(DAZ)) uClsB (.op(in_b[W-2:0]), .cls(clsB));

    logic sgn, nanA, nanB, anyNan, anySnan, zeroA, zeroB, infA, infB, bothSame, special;
    logic [W-1:0] infVal, zeroVal, specResult;
    logic specInvalid, specDivzero;

    assign sgn      = in_a[W-1] ^ in_b[W-1];
    assign nanA     = clsA == QNAN || clsA == SNAN;
    assign nanB     = clsB == QNAN || clsB == SNAN;
    assign anyNan   = nanA || nanB;
    assign anySnan  = clsA == SNAN || clsB == SNAN;
    assign zeroA    = clsA == ZERO;
    assign zeroB    = clsB == ZERO;
    assign infA     = clsA == INF;
    assign infB     = clsB == INF;
    assign bothSame = (zeroA && zeroB) || (infA && infB);
    // Any zero, inf or NaN operand is resolved locally; only finite/finite reaches the core
    assign special  = anyNan || zeroA || zeroB || infA || infB;
    assign infVal   = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    assign zeroVal  = {sgn, {(W-1){1'b0}}};

    assign specResult  = (anyNan || bothSame) ? qnanVal :
                         infA ? infVal : (infB || zeroA) ? zeroVal : infVal;
    assign specInvalid = anyNan ? anySnan : bothSame;
    assign specDivzero = !anyNan && !infA && !zeroA && zeroB;

    assign in_ready = state == IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            core_start  <= 1'b0;
            core_a      <= '0;
            core_b      <= '0;
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_invalid <= 1'b0;
            out_divzero <= 1'b0;
        end else begin
            core_start <= 1'b0;
            case (state)
                IDLE: if (in_valid) begin
                    if (special) begin
                        out_result  <= specResult;
                        out_invalid <= specInvalid;
                        out_divzero <= specDivzero;
                        out_valid   <= 1'b1;
                        state       <= OUT_HOLD;
                    end else begin
                        core_a     <= in_a;
                        core_b     <= in_b;
                        core_start <= 1'b1;
                        state      <= CORE_WAIT;
                    end
                end
                CORE_WAIT: if (core_done) begin
                    out_result  <= core_result;
                    out_invalid <= 1'b0;
                    out_divzero <= 1'b0;
                    out_valid   <= 1'b1;
                    state       <= OUT_HOLD;
                end
                OUT_HOLD: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpdiv_special_ctrl.sv
// tb_fpdiv_special_ctrl: directed table-driven bench for the divider special-case controller
module tb_fpdiv_special_ctrl;
    logic clk = 1'b0, rst_n = 1'b0;
    logic in_valid = 1'b0, in_ready;
    logic [31:0] in_a = '0, in_b = '0;
    logic core_start, core_done = 1'b0;
    logic [31:0] core_a, core_b, core_result = '0;
    logic out_valid, out_ready = 1'b0, out_invalid, out_divzero;
    logic [31:0] out_result;

    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    fpdiv_special_ctrl #(.EXP_W(8), .MAN_W(23), .DAZ(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .core_start(core_start), .core_a(core_a), .core_b(core_b),
        .core_done(core_done), .core_result(core_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_invalid(out_invalid), .out_divzero(out_divzero)
    );

    typedef struct packed {
        logic [31:0] a, b, res;
        logic        inv, dz;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    initial begin
        vecs[0]  = '{32'h40C00000, 32'h00000000, 32'h7F800000, 1'b0, 1'b1};
        vecs[1]  = '{32'hFF800000, 32'h7F800000, 32'h7FC00000, 1'b1, 1'b0};
        vecs[2]  = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 1'b1, 1'b0};
        vecs[3]  = '{32'h80000000, 32'h3F800000, 32'h80000000, 1'b0, 1'b0};
        vecs[4]  = '{32'h00000001, 32'h3F800000, 32'h00000000, 1'b0, 1'b0};
        vecs[5]  = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b0};
        vecs[6]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 1'b1, 1'b0};
        vecs[7]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0, 1'b0};
        vecs[8]  = '{32'h3F800000, 32'hFF800000, 32'h80000000, 1'b0, 1'b0};
        vecs[9]  = '{32'hBF800000, 32'h00000000, 32'hFF800000, 1'b0, 1'b1};
        vecs[10] = '{32'h7F800000, 32'h00000000, 32'h7F800000, 1'b0, 1'b0};
        vecs[11] = '{32'h00000000, 32'h7FC00000, 32'h7FC00000, 1'b0, 1'b0};
        vecs[12] = '{32'h3F800000, 32'h7F800001, 32'h7FC00000, 1'b1, 1'b0};
        vecs[13] = '{32'h00000000, 32'h80000001, 32'h7FC00000, 1'b1, 1'b0};

        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_core_start", 32'(core_start), 32'd0);
        chk("rst_core_a", core_a, 32'h0);
        chk("rst_core_b", core_b, 32'h0);
        chk("rst_out_result", out_result, 32'h0);
        chk("rst_flags", {30'd0, out_invalid, out_divzero}, 32'd0);
        rst_n = 1'b1;

        // Special-case table: result one cycle after accept, no core launch
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_a = vecs[i].a; in_b = vecs[i].b; out_ready = 1'b0;
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("v%0d_result", i), out_result, vecs[i].res);
            chk($sformatf("v%0d_invalid", i), 32'(out_invalid), 32'(vecs[i].inv));
            chk($sformatf("v%0d_divzero", i), 32'(out_divzero), 32'(vecs[i].dz));
            chk($sformatf("v%0d_no_start", i), 32'(core_start), 32'd0);
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd0);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            chk($sformatf("v%0d_released", i), {30'd0, out_valid, in_ready}, 32'd1);
        end

        // Core path with delayed done and output back-pressure
        @(negedge clk);
        in_valid = 1'b1; in_a = 32'h40C00000; in_b = 32'h40000000;
        @(negedge clk);
        in_valid = 1'b0;
        chk("core_start_pulse", 32'(core_start), 32'd1);
        chk("core_a", core_a, 32'h40C00000);
        chk("core_b", core_b, 32'h40000000);
        chk("core_wait_no_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("core_start_one_cycle", 32'(core_start), 32'd0);
        repeat (3) @(negedge clk);
        chk("core_ops_stable", core_a ^ core_b, 32'h40C00000 ^ 32'h40000000);
        core_done = 1'b1; core_result = 32'h40400000;
        @(negedge clk);
        core_done = 1'b0; core_result = 32'h12345678;
        chk("core_out_valid", 32'(out_valid), 32'd1);
        chk("core_result", out_result, 32'h40400000);
        chk("core_flags", {30'd0, out_invalid, out_divzero}, 32'd0);
        in_valid = 1'b1; in_a = 32'h00000000; in_b = 32'h00000000;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) core_done = 1'b1;
            @(negedge clk);
            core_done = 1'b0;
            chk($sformatf("hold%0d_valid", c), 32'(out_valid), 32'd1);
            chk($sformatf("hold%0d_result", c), out_result, 32'h40400000);
            chk($sformatf("hold%0d_in_ready", c), 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("hold_release", {30'd0, out_valid, in_ready}, 32'd1);

        // Reset during CORE_WAIT aborts; stray done afterwards is ignored
        in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h40000000;
        @(negedge clk);
        in_valid = 1'b0;
        chk("abort_launch", 32'(core_start), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_idle", 32'(in_ready), 32'd1);
        core_done = 1'b1; core_result = 32'h3F000000;
        @(negedge clk);
        core_done = 1'b0;
        chk("abort_no_valid", 32'(out_valid), 32'd0);
        chk("abort_still_idle", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("abort_no_valid_later", 32'(out_valid), 32'd0);

        // Back-to-back special ops with out_ready tied high
        begin
            int idx = 0, got = 0, lastCyc = -1;
            out_ready = 1'b1;
            for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
                @(negedge clk);
                if (out_valid) begin
                    chk($sformatf("b2b%0d_result", got), out_result, vecs[got].res);
                    if (lastCyc >= 0) chk($sformatf("b2b%0d_spacing", got), 32'(cyc - lastCyc), 32'd2);
                    lastCyc = cyc;
                    got++;
                end
                if (in_ready) begin
                    in_valid = idx < 4;
                    if (idx < 4) begin
                        in_a = vecs[idx].a; in_b = vecs[idx].b;
                        idx++;
                    end
                end
            end
            in_valid = 1'b0;
            chk("b2b_count", 32'(got), 32'd4);
            @(negedge clk);
            chk("b2b_no_dup", 32'(out_valid), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fpdiv_special_ctrl.md
# fpdiv_special_ctrl

Parametrised front-end and result-merge controller for the iterative floating-point divider. It classifies operands and resolves NaN, infinity, zero and (optionally) subnormal cases in one cycle. Only ordinary finite/finite quotients are dispatched to the divider core over a start/done handshake. The final quotient and IEEE exception flags are returned on a valid/ready output port; the block sits between the FPAU issue stage and the divider datapath.

## Interface
- `EXP_W`, 8, exponent width.
- `MAN_W`, 23, stored mantissa width. Local constant `W = 1+EXP_W+MAN_W`.
- `DAZ`, 1, when 1 subnormal inputs are treated as zero of the same sign; when 0 they go to the core.
- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  block can accept operands.
- `in_a`  in  W  dividend.
- `in_b`  in  W  divisor.
- `core_start`  out  1  single-cycle launch pulse to divider core.
- `core_a`, `core_b`  out  W  registered operands to core, stable from `core_start` until `core_done`.
- `core_done`  in  1  core result valid, single-cycle pulse.
- `core_result`  in  W  core quotient.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `out_result`  out  W  quotient.
- `out_invalid`  out  1  invalid-operation flag.
- `out_divzero`  out  1  divide-by-zero flag.

## Operation
- FSM states: IDLE, CORE_WAIT, OUT_HOLD. `in_ready = (state==IDLE)`. One operation is in flight at a time.
- IDLE: on `in_valid`, classify both operands. If a special case applies, register result and flags, then go to OUT_HOLD. Otherwise register operands to `core_a/b`, pulse `core_start` for exactly one cycle, then go to CORE_WAIT.
- CORE_WAIT: on `core_done`, capture `core_result` with flags 0, then go to OUT_HOLD. `core_done` in any other state is ignored.
- OUT_HOLD: `out_valid=1`. Result and flags are held stable until `out_ready`, then go to IDLE.
- Special-case rules use `s = sign_a ^ sign_b` and canonical qNaN = {0, all-ones exponent, mantissa MSB 1, rest 0}. Rules are evaluated in this priority order:
  - Either operand NaN → qNaN. `invalid=1` if either is signalling (mantissa MSB 0).
  - 0/0 or inf/inf → qNaN, `invalid=1`.
  - inf/finite → inf with sign s.
  - finite/inf → zero with sign s.
  - 0/nonzero finite → zero with sign s.
  - nonzero finite/0 → inf with sign s, `divzero=1`.
- Classification: exponent all-ones with mantissa 0 is inf; exponent all-ones with mantissa ≠0 is NaN; exponent 0 with mantissa 0 is zero; exponent 0 with mantissa ≠0 is subnormal (zero if DAZ=1).
- Core results pass through unmodified.

## Timing
- Reset values: state IDLE, `out_valid=0`, `out_result=0`, both flags 0, `core_start=0`, `core_a/b=0`.
- Special-path latency: the accept edge loads the result; `out_valid` is high from the next cycle.
- Core path: `core_start` is high in the cycle after the accept edge. `out_valid` rises the cycle after `core_done` is sampled.
- Back-pressure: with `out_ready` low, outputs are unchanged and `in_ready=0`. Throughput is one operation per 2 cycles minimum (special path, `out_ready` tied high).
- Reset mid-operation aborts the operation with no output. A later stray `core_done` is ignored.
- `in_valid` with `in_ready=0` is not consumed. The upstream stage holds its operands.

## Structure
- Package `fpdiv_pkg` holds the state enum, the operand class enum (ZERO, SUB, NORM, INF, QNAN, SNAN), and a `qnan(EXP_W,MAN_W)` constant function.
- Sub-module `fp_classify` is parametrised by EXP_W, MAN_W and DAZ, and is instantiated once per operand. It is purely combinational.

## Test plan
- 0x40C00000 / 0x00000000 → 0x7F800000, `divzero=1`, no `core_start`, `out_valid` one cycle after accept.
- 0xFF800000 / 0x7F800000 → 0x7FC00000, `invalid=1`. Also 0x7F800001 / 0x3F800000 (sNaN) → 0x7FC00000, `invalid=1`.
- 0x80000000 / 0x3F800000 → 0x80000000, flags 0. With DAZ=1, 0x00000001 / 0x3F800000 → 0x00000000 without a core launch.
- 0x40C00000 / 0x40000000: one-cycle `core_start` with operands; `core_done` 5 cycles later with 0x40400000 → `out_result` 0x40400000, flags 0. `out_ready` held low 3 cycles keeps the output stable and `in_ready` low.
- Assert `rst_n` low during CORE_WAIT, release, then pulse `core_done` → `out_valid` stays 0 and state is IDLE.
- Back-to-back special operations with `out_ready=1` → one result every 2 cycles, no drops or duplicates.
